// File: rtl/delay_sched_pkg.sv
// Shared types and sizing helpers for the delay-paced sweep scheduler.
// Holds the FSM state encoding, default widths and the count ceiling helper.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW_DEFAULT = 4;
    localparam int DW_DEFAULT = 3;

    function automatic int cnt_max(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage

// File: rtl/delay_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after the pointer, wrapping.
// Latency: purely combinational; backpressure: none, enable low forces no grant.
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   pointer,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index
);

    always_comb begin
        logic          found;
        logic [IW-1:0] pos;
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(pointer) + k) % NREQ);
            if (enable && !found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                index      = pos;
            end
        end
    end

endmodule

// File: rtl/delay_scheduler.sv
// delay_scheduler: round-robin owner of one delay-paced 0..CNT_MAX sweep; optional DELAY_SCHED_ABORT_EN.
// Latency: grant one cycle after req seen in IDLE; done at G+(CNT_MAX+1)*(dly+1); no backpressure, req is a level.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] delay_in,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [CW-1:0]      count,
    output logic               step,
    output logic [NREQ-1:0]    done
`ifdef DELAY_SCHED_ABORT_EN
    ,
    output logic               aborted
`endif
);

    localparam int            IW       = $clog2(NREQ);
    localparam logic [CW-1:0] CNT_MAX  = CW'(cnt_max(CW));
    localparam logic [CW-1:0] CNT_LAST = CNT_MAX - CW'(1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [DW-1:0]   dly;
    logic [DW-1:0]   presc;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   next_ptr;
    logic            tick;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req),
        .pointer (ptr),
        .enable  (state == IDLE),
        .grant   (arb_gnt),
        .index   (arb_idx)
    );

    assign next_ptr = IW'((int'(gidx) + 1) % NREQ);
    assign tick     = (presc == dly);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            gidx  <= '0;
            dly   <= '0;
            presc <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            count <= '0;
            step  <= 1'b0;
            done  <= '0;
`ifdef DELAY_SCHED_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            step <= 1'b0;
            done <= '0;
`ifdef DELAY_SCHED_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        gnt   <= arb_gnt;
                        gidx  <= arb_idx;
                        dly   <= delay_in[int'(arb_idx)*DW +: DW];
                        busy  <= 1'b1;
                        count <= '0;
                        presc <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc <= '0;
                        count <= count + CW'(1);
                        step  <= 1'b1;
                        if (count == CNT_LAST) begin
                            state <= HOLD;
                        end
                    end else begin
                        presc <= presc + DW'(1);
                    end
                end
                HOLD: begin
                    // Dwell at the top for one full step period before completing.
                    if (tick) begin
                        presc <= '0;
                        done  <= gnt;
                        gnt   <= '0;
                        count <= '0;
                        state <= DONE;
                    end else begin
                        presc <= presc + DW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef DELAY_SCHED_ABORT_EN
            // Owner withdrew mid-run: drop the sweep and pass priority along.
            if ((state == RUN || state == HOLD) && !req[gidx]) begin
                state   <= IDLE;
                gnt     <= '0;
                count   <= '0;
                busy    <= 1'b0;
                presc   <= '0;
                step    <= 1'b0;
                done    <= '0;
                ptr     <= next_ptr;
                aborted <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Randomized bench for delay_scheduler against a run-timeline reference model.
module tb_delay_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int DW   = 3;
    localparam int CMAX = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] delay_in;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [CW-1:0]      count;
    logic               step;
    logic [NREQ-1:0]    done;
`ifdef DELAY_SCHED_ABORT_EN
    logic               aborted;
`endif

    delay_scheduler #(.NREQ(NREQ), .CW(CW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .delay_in (delay_in),
        .gnt      (gnt),
        .busy     (busy),
        .count    (count),
        .step     (step),
        .done     (done)
`ifdef DELAY_SCHED_ABORT_EN
        ,
        .aborted  (aborted)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a run is described by owner, period and cycles elapsed since the grant.
    bit m_act;
    bit m_abt;
    int m_t;
    int m_cur;
    int m_p;
    int m_ptr;

    task automatic check_outputs();
        logic [31:0] eg, eb, ec, es, ed;
        eg = 0; eb = 0; ec = 0; es = 0; ed = 0;
        if (m_act && m_t < (CMAX + 1) * m_p) begin
            eg = 32'(1) << m_cur;
            eb = 1;
            ec = 32'(m_t / m_p);
            es = 32'((m_t > 0) && (m_t % m_p == 0) && (m_t <= CMAX * m_p));
        end else if (m_act) begin
            eb = 1;
            ed = 32'(1) << m_cur;
        end
        check_eq("gnt", 32'(gnt), eg);
        check_eq("busy", 32'(busy), eb);
        check_eq("count", 32'(count), ec);
        check_eq("step", 32'(step), es);
        check_eq("done", 32'(done), ed);
`ifdef DELAY_SCHED_ABORT_EN
        check_eq("aborted", 32'(aborted), 32'(m_abt));
`endif
    endtask

    task automatic model_step();
        bit found;
        m_abt = 1'b0;
        if (reset) begin
            m_act = 1'b0;
            m_ptr = 0;
        end else if (m_act) begin
            if (m_t == (CMAX + 1) * m_p) begin
                m_act = 1'b0;
                m_ptr = (m_cur + 1) % NREQ;
            end
`ifdef DELAY_SCHED_ABORT_EN
            else if (!req[m_cur]) begin
                m_act = 1'b0;
                m_abt = 1'b1;
                m_ptr = (m_cur + 1) % NREQ;
            end
`endif
            else begin
                m_t++;
            end
        end else if (req != '0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[(m_ptr + k) % NREQ]) begin
                    found = 1'b1;
                    m_cur = (m_ptr + k) % NREQ;
                end
            end
            m_act = 1'b1;
            m_t   = 0;
            m_p   = int'(delay_in[m_cur*DW +: DW]) + 1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        delay_in = '0;
        m_act = 1'b0; m_abt = 1'b0; m_t = 0; m_cur = 0; m_p = 1; m_ptr = 0;
        for (int c = 0; c < 3400; c++) begin
            @(negedge clk);
            check_outputs();
            reset = 1'b0;
            if (c < 3) begin
                reset = 1'b1;
                req   = '0;
            end else if (c < 45) begin
                req      = 4'b0001;
                delay_in = '0;
            end else if (c < 50) begin
                req = '0;
            end else if (c < 120) begin
                req      = 4'b0010;
                delay_in = '0;
                delay_in[1*DW +: DW] = 3'd2;
            end else if (c < 130) begin
                req = '0;
            end else if (c < 235) begin
                req      = 4'b1111;
                delay_in = '0;
            end else if (c < 240) begin
                req = '0;
            end else if (c < 300) begin
                // Latch d=1 at grant, then keep rewriting the delay to 7 mid-run.
                req = 4'b0100;
                if (!m_act) delay_in = {4{3'd1}};
                else        delay_in = {4{3'd7}};
            end else if (c < 700) begin
                req = 4'b1111;
                for (int i = 0; i < NREQ; i++)
                    delay_in[i*DW +: DW] = DW'($urandom);
            end else begin
                reset = ($urandom_range(249) == 0);
                if ($urandom_range(15) == 0) req = NREQ'($urandom);
                for (int i = 0; i < NREQ; i++)
                    if ($urandom_range(3) == 0) delay_in[i*DW +: DW] = DW'($urandom);
            end
            model_step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/delay_scheduler.md
Name: delay_scheduler

Overview:
- Controller that shares one delay-paced step counter (0..CNT_MAX, one step every delay+1 cycles) between NREQ requesters.
- Round-robin arbitration; the winner's delay is latched, a full sweep is run, and then a dwell at the top equal to one step period.
- Completion is signalled per requester. It sits between per-channel sequencers and the shared sweep/timing output.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 4, count width; CNT_MAX = 2**CW-1
- DW, 3, delay field width per requester

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester, level
- delay_in  in  NREQ*DW  packed delays, requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, held for whole run
- busy  out  1  high in RUN/HOLD/DONE
- count  out  CW  current sweep value
- step  out  1  one-cycle pulse in the cycle count shows a new incremented value
- done  out  NREQ  one-cycle pulse to the served requester on completion

Behaviour:
- Reset: one clock, synchronous, active-high; checked before all else. Reset values: gnt=0, busy=0, count=0, step=0, done=0, state=IDLE, rr pointer=0, prescaler=0, latched delay=0.
- All outputs are registered.
- States: IDLE, RUN, HOLD, DONE.
- IDLE
  - If req!=0, pick the first set bit at or after the pointer, wrapping.
  - Next cycle (call it G): gnt[i]=1, busy=1, count=0, prescaler=0, dly=delay_in[i], state=RUN.
- Step period P = dly+1 cycles. dly=0 gives a step every cycle; no zero-delay special case.
- RUN
  - Each cycle, if prescaler==dly: prescaler<=0, count<=count+1, step<=1.
  - Otherwise prescaler++.
  - count=k appears at cycle G+k*P.
  - When the increment produces CNT_MAX, state=HOLD.
- HOLD
  - count held at CNT_MAX for P cycles (G+CNT_MAX*P .. G+(CNT_MAX+1)*P-1); no step pulses.
  - Then DONE.
- DONE (single cycle, G+(CNT_MAX+1)*P)
  - done[i]=1, gnt=0, count=0, busy=1.
  - pointer <= (i+1) mod NREQ.
  - Next state IDLE.
- Minimum gap between runs: a grant is never issued in DONE. IDLE lasts at least one cycle, so the next gnt is at DONE+2.
- Ignored inputs:
  - delay_in changes after grant have no effect; dly is latched.
  - req changes of non-granted requesters during a run have no effect.
- Dropping req[i] during a run is ignored, unless the optional feature below is enabled.
- Simultaneous requests: strict round-robin from the pointer, so no requester is starved. Worst-case wait is (NREQ-1) runs.
- Reset mid-run: everything returns to reset values on the next edge. No done pulse; pointer returns to 0.
- Invariants:
  - gnt is at most one-hot.
  - done is only ever asserted on the bit that was granted.
  - count never exceeds CNT_MAX and never wraps.

Optional Feature:
- Macro: DELAY_SCHED_ABORT_EN.
- Defined: if req[i] of the granted requester is 0 in any RUN or HOLD cycle, the next cycle is IDLE.
  - gnt=0, count=0, busy=0, no done pulse.
  - Pointer advances to (i+1) mod NREQ.
  - One-bit output "aborted" pulses for one cycle.
- Not defined: the req of the granted requester is don't-care after grant, and the "aborted" port does not exist.

Decomposition:
- Package delay_sched_pkg holds:
  - enum state_t {IDLE, RUN, HOLD, DONE}
  - default CW and DW localparams
  - function cnt_max(CW)
- One sub-module, rr_arbiter:
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational priority rotate, instantiated once.
- Prescaler and sweep counter stay inline.

Test Plan:
- Single requester, d=0: req=0001 → gnt=0001 at G; count=15 at G+15; done[0] pulse at G+16; 15 step pulses.
- Single requester, d=2: req=0010, delay_in[1]=2 → step every 3 cycles; count=15 at G+45; hold 3 cycles; done[1] at G+48.
- Contention: req=1111 held, all d=0 → grant order 0,1,2,3,0; successive grants 18 cycles apart; gnt always one-hot.
- Delay change mid-run: d=1 latched, delay_in switched to 7 at G+5 → period stays 2; done at G+32.
- Reset mid-run: reset high at G+10 for 1 cycle → next cycle gnt=0, count=0, busy=0; no done; next grant goes to lowest set req.
- Abort (DELAY_SCHED_ABORT_EN): req[2] drops at G+4 → next cycle IDLE, aborted=1, done=0, pointer=3.
